// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants for the iterative binary-to-BCD converter
package bin2bcd_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Largest value the four-digit display can show
    localparam logic [13:0] BCD_MAX   = 14'd9999;

    // Digit shown on every position when the value does not fit
    localparam logic [3:0]  DIGIT_OVF = 4'hF;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// rtl/bin2bcd_seq_digit_adj.sv - double-dabble add-3 correction for one BCD nibble
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Nibbles of 5 or more would exceed 9 after the next doubling, so pre-add 3
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative binary-to-BCD converter, one bit per clock, for the 4-digit display
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [3:0]       num3,
    output logic [3:0]       num4
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    logic [1:0]       state;
    logic [BIN_W-1:0] shreg;
    logic [15:0]      accum;
    logic [15:0]      accum_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_cap;
    logic [13:0]      bin_ext;

    // Narrower inputs are zero-extended so the range check is always against 9999
    assign bin_ext = 14'(bin_in);

    // The display only ever sees num1..num4, so busy can follow the state directly
    assign busy = (state != ST_IDLE);

    // Per-nibble add-3 correction applied before every shift
    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (accum[4*g +: 4]),
            .dout (accum_adj[4*g +: 4])
        );
    end

    // Control FSM and shift datapath: capture, BIN_W shift-add-3 steps, then publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            accum   <= '0;
            bit_cnt <= '0;
            ovf_cap <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        accum   <= '0;
                        bit_cnt <= '0;
                        ovf_cap <= (bin_ext > BCD_MAX);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    accum   <= {accum_adj[14:0], shreg[BIN_W-1]};
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output registers change only when leaving DONE, so partial results never reach the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            ovf  <= 1'b0;
            num1 <= 4'h0;
            num2 <= 4'h0;
            num3 <= 4'h0;
            num4 <= 4'h0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                ovf <= ovf_cap;
                if (ovf_cap) begin
                    num1 <= DIGIT_OVF;
                    num2 <= DIGIT_OVF;
                    num3 <= DIGIT_OVF;
                    num4 <= DIGIT_OVF;
                end else begin
                    num1 <= accum[15:12];
                    num2 <= accum[11:8];
                    num3 <= accum[7:4];
                    num4 <= accum[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  num1;
    logic [3:0]  num2;
    logic [3:0]  num3;
    logic [3:0]  num4;

    bin2bcd_seq #(.BIN_W(14)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .num1   (num1),
        .num2   (num2),
        .num3   (num3),
        .num4   (num4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        eovf;
        int          ecyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=%h%h%h%h exp=none", num1, num2, num3, num4);
            end else begin
                mon_e = sb.pop_front();
                chk("result_digits", {16'h0, num1, num2, num3, num4}, {16'h0, mon_e.digits});
                chk("result_ovf", {31'h0, ovf}, {31'h0, mon_e.eovf});
                chk("done_latency", cyc, mon_e.ecyc);
                chk("busy_at_done", {31'h0, busy}, 32'h0);
            end
            if (prev_done) begin
                checks++;
                failures++;
                $display("FAIL done_twice got=1 exp=0");
            end
        end
        prev_done = done;
    end

    // Called #1 after a rising edge with busy low; start is accepted on the next edge
    task automatic issue(input logic [13:0] v, input logic [15:0] ed, input logic eo, input bit push);
        exp_t e;
        start  = 1'b1;
        bin_in = v;
        if (push) begin
            e.digits = ed;
            e.eovf   = eo;
            e.ecyc   = cyc + 16;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic chk_out(input string nm, input logic [15:0] ed, input logic eo);
        chk(nm, {16'h0, num1, num2, num3, num4}, {16'h0, ed});
        chk({nm, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk_out("reset_out", 16'h0000, 1'b0);

        issue(14'd1234, 16'h1234, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", {31'h0, busy}, 32'h1);
        chk_out("hold_before_1234", 16'h0000, 1'b0);
        wait_done();

        issue(14'd9999, 16'h9999, 1'b0, 1'b1);
        wait_done();
        issue(14'd0, 16'h0000, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk_out("hold_9999", 16'h9999, 1'b0);
        wait_done();

        issue(14'd10000, 16'hFFFF, 1'b1, 1'b1);
        wait_done();
        issue(14'd42, 16'h0042, 1'b0, 1'b1);
        wait_done();

        issue(14'd567, 16'h0567, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 14'd8888;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        chk_out("hold_567", 16'h0567, 1'b0);

        issue(14'd4321, 16'h0000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk_out("rst_mid_out", 16'h0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk_out("after_rst_out", 16'h0000, 1'b0);
        issue(14'd4321, 16'h4321, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
